// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register built on a DEPTH-entry
// circular buffer. DEPTH=1 is a classic stage register, DEPTH=2 a skid buffer.
// Optional statistics counters are built only when PIPE_STAGE_STATS_EN is
// defined; otherwise stall_cycles/bubble_cycles are tied to zero.
module pipe_stage_buf #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] occupancy,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      bubble_cycles
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake status derives from registered occupancy only, so there is
   // no combinational path from out_ready back to in_ready.
   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign occupancy = count;

   // Flush overrides both sides of the handshake.
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   // Payload storage: written at the tail on every accepted push. Flush
   // leaves contents in place; the pointers make them unreachable.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush empties the stage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   // Counters stick at all-ones rather than wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Stall/bubble statistics; cleared only by reset, not by flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cycles  <= '0;
         bubble_cycles <= '0;
      end else begin
         if (out_valid && !out_ready) begin
            stall_cycles <= sat_inc(stall_cycles);
         end
         if (!out_valid && out_ready) begin
            bubble_cycles <= sat_inc(bubble_cycles);
         end
      end
   end
`else
   assign stall_cycles  = '0;
   assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: a DEPTH=2 instance for
// reset, streaming, back-pressure, flush and statistics, and a DEPTH=3
// instance for pointer wrap-around under a fixed out_ready pattern.
module tb_pipe_stage_buf;

   logic       clk = 1'b0;
   logic       rstn;

   // DEPTH=2 instance
   logic       flush, iv, ir, ov, ordy;
   logic [7:0] id, od;
   logic [1:0] occ;
   logic [31:0] stc, bbc;

   // DEPTH=3 instance
   logic       flush3, iv3, ir3, ov3, or3;
   logic [7:0] id3, od3;
   logic [1:0] occ3;
   logic [31:0] stc3, bbc3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.WIDTH(8), .DEPTH(2)) u_dut (
      .clk(clk), .resetn(rstn), .flush(flush),
      .in_valid(iv), .in_ready(ir), .in_data(id),
      .out_valid(ov), .out_ready(ordy), .out_data(od),
      .occupancy(occ), .stall_cycles(stc), .bubble_cycles(bbc)
   );

   pipe_stage_buf #(.WIDTH(8), .DEPTH(3)) u_dut3 (
      .clk(clk), .resetn(rstn), .flush(flush3),
      .in_valid(iv3), .in_ready(ir3), .in_data(id3),
      .out_valid(ov3), .out_ready(or3), .out_data(od3),
      .occupancy(occ3), .stall_cycles(stc3), .bubble_cycles(bbc3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] pat;
      int sent, got, mc;
      logic mpush, mpop;

      rstn = 1'b0; flush = 1'b0; iv = 1'b0; id = '0; ordy = 1'b0;
      flush3 = 1'b0; iv3 = 1'b0; id3 = '0; or3 = 1'b0;

      // 1. reset and idle
      repeat (3) tick();
      chk("rst_out_valid", ov, 0);
      chk("rst_in_ready", ir, 1);
      chk("rst_occ", occ, 0);
      chk("rst_out_data", od, 0);
      rstn = 1'b1;
      tick();
      chk("idle_out_valid", ov, 0);
      chk("idle_in_ready", ir, 1);

      // 2. streaming at full rate
      ordy = 1'b1;
      iv = 1'b1; id = 8'h11;
      chk("s_in_ready0", ir, 1);
      tick();
      id = 8'h22;
      chk("s_data0", od, 8'h11);
      chk("s_in_ready1", ir, 1);
      tick();
      id = 8'h33;
      chk("s_data1", od, 8'h22);
      chk("s_in_ready2", ir, 1);
      tick();
      iv = 1'b0;
      chk("s_data2", od, 8'h33);
      chk("s_in_ready3", ir, 1);
      tick();
      chk("s_drained", ov, 0);

      // 3. back-pressure
      ordy = 1'b0;
      iv = 1'b1; id = 8'h0A;
      tick();
      id = 8'h0B;
      chk("bp_in_ready1", ir, 1);
      tick();
      id = 8'h0C;
      chk("bp_occ_full", occ, 2);
      chk("bp_in_ready_full", ir, 0);
      chk("bp_head", od, 8'h0A);
      tick();
      chk("bp_occ_hold", occ, 2);
      ordy = 1'b1;
      chk("bp_no_pop_bypass", ir, 0);
      chk("bp_pop_a", od, 8'h0A);
      tick();
      chk("bp_in_ready_back", ir, 1);
      chk("bp_pop_b", od, 8'h0B);
      tick();
      iv = 1'b0;
      chk("bp_pop_c", od, 8'h0C);
      tick();
      chk("bp_empty", ov, 0);

      // 4. flush
      ordy = 1'b0;
      iv = 1'b1; id = 8'h05;
      tick();
      id = 8'h06;
      tick();
      chk("fl_occ_pre", occ, 2);
      flush = 1'b1; id = 8'h07;
      tick();
      flush = 1'b0; iv = 1'b0;
      chk("fl_occ", occ, 0);
      chk("fl_out_valid", ov, 0);
      chk("fl_in_ready", ir, 1);
      chk("fl_out_data", od, 0);
      flush = 1'b1; iv = 1'b1; id = 8'h09;
      tick();
      flush = 1'b0; iv = 1'b0;
      chk("fl_drop_push", occ, 0);
      iv = 1'b1; id = 8'h08;
      tick();
      iv = 1'b0;
      chk("fl_next_first", od, 8'h08);
      chk("fl_next_occ", occ, 1);
      ordy = 1'b1;
      tick();
      ordy = 1'b0;
      chk("fl_final_empty", ov, 0);

      // 5. wrap-around on DEPTH=3 with an independent occupancy model
      pat = 16'b1110_0101_1011_0000;
      sent = 0; got = 0; mc = 0;
      for (int c = 0; c < 200 && got < 10; c++) begin
         iv3 = (sent < 10);
         id3 = 8'(sent);
         or3 = pat[c % 16];
         chk("w_in_ready", ir3, (mc < 3));
         chk("w_out_valid", ov3, (mc != 0));
         chk("w_occ", occ3, mc);
         mpush = iv3 && (mc < 3);
         mpop  = (mc != 0) && or3;
         if (mpop) begin
            chk("w_data", od3, got);
            got++;
         end
         if (mpush) sent++;
         mc = mc + int'(mpush) - int'(mpop);
         tick();
      end
      iv3 = 1'b0; or3 = 1'b0;
      chk("w_total", got, 10);

      // 6. statistics counters
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      ordy = 1'b0;
      tick();
`ifdef PIPE_STAGE_STATS_EN
      chk("st_rst_stall", stc, 0);
      chk("st_rst_bubble", bbc, 0);
      iv = 1'b1; id = 8'h42;
      tick();
      iv = 1'b0;
      repeat (5) tick();
      chk("st_stall", stc, 5);
      ordy = 1'b1;
      tick();
      repeat (3) tick();
      ordy = 1'b0;
      chk("st_bubble", bbc, 3);
      chk("st_stall_keep", stc, 5);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("st_flush_stall", stc, 5);
      chk("st_flush_bubble", bbc, 3);
`else
      iv = 1'b1; id = 8'h42;
      tick();
      iv = 1'b0;
      repeat (3) tick();
      ordy = 1'b1;
      repeat (3) tick();
      ordy = 1'b0;
      chk("st_off_stall", stc, 0);
      chk("st_off_bubble", bbc, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
